// File: rtl/mips_axi_pkg.sv
// mips_axi_pkg: shared FSM encoding and AXI response codes for the memory arbiter
package mips_axi_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_t;
  localparam logic [1:0] AXI_OKAY = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
endpackage

// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if: AXI4-lite style bus between the arbiter (master) and memory (slave)
interface mips_mem_arbiter_if;
  logic [31:0] araddr;
  logic arvalid, arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid, rready;
  logic [31:0] awaddr;
  logic awvalid, awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/mips_rr_arb2.sv
// mips_rr_arb2: two-way round-robin grant; bit 0 = fetch, bit 1 = data
module mips_rr_arb2 (
  input logic mips_cpu_clk,
  input logic mips_cpu_reset_n,
  input logic en,
  input logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_data;
  logic fetch_win;
  assign fetch_win = req[0] & (~req[1] | last_data);
  assign gnt = en ? {req[1] & ~fetch_win, fetch_win} : 2'b00;
  // last winner starts as data so fetch wins the first tie
  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n)
    if (!mips_cpu_reset_n) last_data <= 1'b1;
    else if (|gnt) last_data <= gnt[1];
endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: arbitrates fetch and data requests onto a single AXI master, one transaction at a time
module mips_mem_arbiter
  import mips_axi_pkg::*;
(
  input logic mips_cpu_clk,
  input logic mips_cpu_reset_n,
  input logic inst_req_valid,
  input logic [31:0] inst_addr,
  output logic inst_req_ack,
  input logic data_req_valid,
  input logic data_we,
  input logic [31:0] data_addr,
  input logic [31:0] data_wdata,
  input logic [3:0] data_wstrb,
  output logic data_req_ack,
  output logic rsp_valid,
  output logic rsp_src,
  output logic [31:0] rsp_rdata,
  output logic rsp_err,
  input logic rsp_ready,
  mips_mem_arbiter_if.master m_axi
);
  state_t state, state_nx;
  logic [1:0] gnt;
  logic [31:0] req_addr;
  logic aw_nx, w_nx;
  mips_rr_arb2 u_rr (
    .mips_cpu_clk(mips_cpu_clk),
    .mips_cpu_reset_n(mips_cpu_reset_n),
    .en(state == IDLE),
    .req({data_req_valid, inst_req_valid}),
    .gnt(gnt)
  );
  assign inst_req_ack = gnt[0];
  assign data_req_ack = gnt[1];
  assign rsp_valid = state == RSP;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = gnt[0] ? RD_ADDR : gnt[1] ? (data_we ? WR_REQ : RD_ADDR) : IDLE;
      RD_ADDR: state_nx = m_axi.arready ? RD_DATA : RD_ADDR;
      RD_DATA: state_nx = m_axi.rvalid ? RSP : RD_DATA;
      WR_REQ:  state_nx = ((~m_axi.awvalid | m_axi.awready) & (~m_axi.wvalid | m_axi.wready)) ? WR_RESP : WR_REQ;
      WR_RESP: state_nx = m_axi.bvalid ? RSP : WR_RESP;
      RSP:     state_nx = rsp_ready ? IDLE : RSP;
      default: state_nx = IDLE;
    endcase
  end
  // each write channel drops on its own handshake
  always_comb begin
    req_addr = gnt[1] ? data_addr : inst_addr;
    aw_nx = (state == IDLE & gnt[1] & data_we) | (state == WR_REQ & m_axi.awvalid & ~m_axi.awready);
    w_nx = (state == IDLE & gnt[1] & data_we) | (state == WR_REQ & m_axi.wvalid & ~m_axi.wready);
  end
  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n)
    if (!mips_cpu_reset_n) begin
      state <= IDLE;
      m_axi.arvalid <= 1'b0;
      m_axi.rready <= 1'b0;
      m_axi.awvalid <= 1'b0;
      m_axi.wvalid <= 1'b0;
      m_axi.bready <= 1'b0;
      m_axi.araddr <= '0;
      m_axi.awaddr <= '0;
      m_axi.wdata <= '0;
      m_axi.wstrb <= '0;
      rsp_src <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      m_axi.arvalid <= state_nx == RD_ADDR;
      m_axi.rready <= state_nx == RD_DATA;
      m_axi.bready <= state_nx == WR_RESP;
      m_axi.awvalid <= aw_nx;
      m_axi.wvalid <= w_nx;
      if (|gnt) begin
        m_axi.araddr <= req_addr;
        m_axi.awaddr <= req_addr;
        m_axi.wdata <= gnt[1] ? data_wdata : '0;
        m_axi.wstrb <= gnt[1] ? data_wstrb : '0;
        rsp_src <= gnt[1];
        rsp_rdata <= '0;
        rsp_err <= 1'b0;
      end
      if (state == RD_DATA && m_axi.rvalid) begin
        rsp_rdata <= m_axi.rdata;
        rsp_err <= |(m_axi.rresp & AXI_SLVERR);
      end
      if (state == WR_RESP && m_axi.bvalid) rsp_err <= |(m_axi.bresp & AXI_SLVERR);
    end
endmodule
